// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID pipeline register, 32x32 register file and
// decode of addu/subu/jr/nop/ori/lui/lw/sw/beq/j/jal.
// Latency: decode outputs are combinational from the IF/ID register (1 edge after fetch).
// Backpressure: stall holds the IF/ID register, flush squashes it and wins over stall.
// Ports: clk/rst (async active-low); instr_in, pc_plus4_in, if_valid from fetch;
//        stall, flush pipeline control; wb_we/wb_addr/wb_data register write port;
//        id_valid, rs_data, rt_data, imm_ext, pc_src, br_target, j_target,
//        reg_write, mem_read, mem_write, alu_src, alu_op, dest_reg, link_data, illegal.
// Build option: define ID_WB_BYPASS_EN to forward wb_data to same-cycle reads.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic [1:0]  pc_src,
  output logic [31:0] br_target,
  output logic [31:0] j_target,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [4:0]  dest_reg,
  output logic [31:0] link_data,
  output logic        illegal
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [5:0]  op, fn;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] sext;
  logic        legal, live;
  logic        rw_c, mr_c, mw_c, as_c, link_c;
  logic [1:0]  pcs_c;
  logic [2:0]  aop_c;
  logic [4:0]  dst_c;

  assign op      = instr_q[31:26];
  assign fn      = instr_q[5:0];
  assign rs_addr = instr_q[25:21];
  assign rt_addr = instr_q[20:16];
  assign rd_addr = instr_q[15:11];
  assign sext    = {{16{instr_q[15]}}, instr_q[15:0]};

  // IF/ID register next state; flush squashes the instruction but leaves pc_plus4
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = instr_in;
      pc4_d   = pc_plus4_in;
      valid_d = if_valid;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_addr != 5'd0)) regs_d[wb_addr] = wb_data;
  end

  // Sticky: latches the first live undecodable instruction until reset
  assign illegal_d = illegal_q | (valid_q & ~legal);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q   <= '0;
      pc4_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      for (int k = 0; k < 32; k++) regs_q[k] <= '0;
    end else begin
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  // Raw decode, before qualification by id_valid/legality
  always_comb begin
    legal  = 1'b0;
    rw_c   = 1'b0;
    mr_c   = 1'b0;
    mw_c   = 1'b0;
    as_c   = 1'b0;
    link_c = 1'b0;
    pcs_c  = 2'd0;
    aop_c  = 3'd0;
    dst_c  = 5'd0;
    case (op)
      6'h00: begin
        case (fn)
          6'h21: begin legal = 1'b1; rw_c = 1'b1; dst_c = rd_addr; end
          6'h23: begin legal = 1'b1; rw_c = 1'b1; dst_c = rd_addr; aop_c = 3'd1; end
          6'h08: begin legal = 1'b1; pcs_c = 2'd3; end
          // only the all-zero sll is accepted, as the canonical nop
          6'h00: legal = (instr_q == 32'h0);
          default: legal = 1'b0;
        endcase
      end
      6'h0d: begin legal = 1'b1; rw_c = 1'b1; as_c = 1'b1; aop_c = 3'd2; dst_c = rt_addr; end
      6'h0f: begin legal = 1'b1; rw_c = 1'b1; as_c = 1'b1; aop_c = 3'd3; dst_c = rt_addr; end
      6'h23: begin legal = 1'b1; rw_c = 1'b1; mr_c = 1'b1; as_c = 1'b1; dst_c = rt_addr; end
      6'h2b: begin legal = 1'b1; mw_c = 1'b1; as_c = 1'b1; end
      // beq always redirects; equality is resolved further down the pipe
      6'h04: begin legal = 1'b1; pcs_c = 2'd1; aop_c = 3'd1; end
      6'h02: begin legal = 1'b1; pcs_c = 2'd2; end
      6'h03: begin legal = 1'b1; pcs_c = 2'd2; rw_c = 1'b1; dst_c = 5'd31; link_c = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // Empty slots and illegal instructions both behave as nops
  assign live = valid_q & legal;

  assign id_valid  = valid_q;
  assign illegal   = illegal_q;
  assign reg_write = live & rw_c;
  assign mem_read  = live & mr_c;
  assign mem_write = live & mw_c;
  assign alu_src   = live & as_c;
  assign pc_src    = live ? pcs_c : 2'd0;
  assign alu_op    = live ? aop_c : 3'd0;
  assign dest_reg  = live ? dst_c : 5'd0;
  assign link_data = (live & link_c) ? pc4_q : 32'h0;

  assign imm_ext   = (op == 6'h0d) ? {16'h0, instr_q[15:0]} :
                     (op == 6'h0f) ? {instr_q[15:0], 16'h0} : sext;
  assign br_target = pc4_q + (sext << 2);
  assign j_target  = {pc4_q[31:28], instr_q[25:0], 2'b00};

`ifdef ID_WB_BYPASS_EN
  assign rs_data = (wb_we && (wb_addr != 5'd0) && (wb_addr == rs_addr)) ? wb_data : regs_q[rs_addr];
  assign rt_data = (wb_we && (wb_addr != 5'd0) && (wb_addr == rt_addr)) ? wb_data : regs_q[rt_addr];
`else
  assign rs_data = regs_q[rs_addr];
  assign rt_data = regs_q[rt_addr];
`endif

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, pc_plus4_in, wb_data;
  logic        if_valid, stall, flush, wb_we;
  logic [4:0]  wb_addr;
  logic        id_valid, reg_write, mem_read, mem_write, alu_src, illegal;
  logic [31:0] rs_data, rt_data, imm_ext, br_target, j_target, link_data;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic [4:0]  dest_reg;

  id_stage dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
    .if_valid(if_valid), .stall(stall), .flush(flush), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .id_valid(id_valid), .rs_data(rs_data),
    .rt_data(rt_data), .imm_ext(imm_ext), .pc_src(pc_src), .br_target(br_target),
    .j_target(j_target), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src), .alu_op(alu_op), .dest_reg(dest_reg),
    .link_data(link_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id_valid;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic        reg_write, mem_read, mem_write, alu_src;
    logic [4:0]  dest_reg;
    logic [31:0] imm_ext, br_target, j_target, link_data, rs_data, rt_data;
    logic        illegal;
  } out_t;

  out_t obs, e;
  assign obs = {id_valid, pc_src, alu_op, reg_write, mem_read, mem_write, alu_src, dest_reg,
                imm_ext, br_target, j_target, link_data, rs_data, rt_data, illegal};

  int checks = 0;
  int errors = 0;
  out_t sb[$];

  // reference state of the decode slot
  logic [31:0] m_instr, m_pc4;
  logic        m_valid, m_ill;
  logic [31:0] m_regs [32];

  function automatic logic legal_of(input logic [31:0] i);
    case (i[31:26])
      6'h00: return (i[5:0] == 6'h21) || (i[5:0] == 6'h23) || (i[5:0] == 6'h08) || (i == 32'h0);
      6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic out_t exp_of();
    out_t r;
    logic [31:0] i, se;
    i  = m_instr;
    se = {{16{i[15]}}, i[15:0]};
    r = '0;
    r.id_valid  = m_valid;
    r.illegal   = m_ill;
    r.imm_ext   = (i[31:26] == 6'h0d) ? {16'h0, i[15:0]} :
                  (i[31:26] == 6'h0f) ? {i[15:0], 16'h0} : se;
    r.br_target = m_pc4 + {se[29:0], 2'b00};
    r.j_target  = {m_pc4[31:28], i[25:0], 2'b00};
    r.rs_data   = m_regs[i[25:21]];
    r.rt_data   = m_regs[i[20:16]];
    if (m_valid && legal_of(i)) begin
      case (i[31:26])
        6'h00: begin
          if (i[5:0] == 6'h21) begin r.reg_write = 1; r.dest_reg = i[15:11]; end
          if (i[5:0] == 6'h23) begin r.reg_write = 1; r.dest_reg = i[15:11]; r.alu_op = 3'd1; end
          if (i[5:0] == 6'h08) r.pc_src = 2'd3;
        end
        6'h0d: begin r.reg_write = 1; r.alu_src = 1; r.alu_op = 3'd2; r.dest_reg = i[20:16]; end
        6'h0f: begin r.reg_write = 1; r.alu_src = 1; r.alu_op = 3'd3; r.dest_reg = i[20:16]; end
        6'h23: begin r.reg_write = 1; r.mem_read = 1; r.alu_src = 1; r.dest_reg = i[20:16]; end
        6'h2b: begin r.mem_write = 1; r.alu_src = 1; end
        6'h04: begin r.pc_src = 2'd1; r.alu_op = 3'd1; end
        6'h02: r.pc_src = 2'd2;
        6'h03: begin r.pc_src = 2'd2; r.reg_write = 1; r.dest_reg = 5'd31; r.link_data = m_pc4; end
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_ill = 1'b0;
    for (int k = 0; k < 32; k++) m_regs[k] = '0;
  endtask

  // Drive one cycle of inputs and push the state expected after the next edge
  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic v,
                       input logic st, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    instr_in = i; pc_plus4_in = p; if_valid = v; stall = st; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    if (m_valid && !legal_of(m_instr)) m_ill = 1'b1;
    if (we && wa != 5'd0) m_regs[wa] = wd;
    if (fl) begin m_valid = 1'b0; m_instr = '0; end
    else if (!st) begin m_instr = i; m_pc4 = p; m_valid = v; end
    sb.push_back(exp_of());
  endtask

  localparam logic [31:0] ADDU = {6'h00, 5'd17, 5'd20, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] LW   = {6'h23, 5'd5, 5'd6, 16'hfffc};

  task automatic test_reset();
    instr_in = 32'h3c11cccc; pc_plus4_in = 32'h1234; if_valid = 1; stall = 0; flush = 0;
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'h5555;
    rst = 0;
    model_reset();
    #1;
    e = exp_of(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_immediate got %h want %h", obs, e); end
    repeat (2) @(posedge clk);
    #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held got %h want %h", obs, e); end
    @(negedge clk);
    rst = 1;
    drive(32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release got %h want %h", obs, e); end
  endtask

  task automatic test_regfile();
    logic [4:0]  wa [4];
    logic [31:0] wd [4];
    wa[0] = 5'd17; wd[0] = 32'h11111717;
    wa[1] = 5'd20; wd[1] = 32'h20200202;
    wa[2] = 5'd5;  wd[2] = 32'h00001000;
    wa[3] = 5'd1;  wd[3] = 32'h80000001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(32'h0, 32'h0, 0, 0, 0, 1, wa[k], wd[k]);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL regfile_wr[%0d] got %h want %h", k, obs, e); end
    end
    @(negedge clk);
    drive(ADDU, 32'h100, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL regfile_rd got %h want %h", obs, e); end
    checks++;
    if ({rs_data, rt_data} !== {32'h11111717, 32'h20200202}) begin
      errors++; $display("FAIL regfile_rsrt got %h %h want 11111717 20200202", rs_data, rt_data);
    end
  endtask

  task automatic test_lui();
    @(negedge clk);
    drive(32'h3c11cccc, 32'h4, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL lui got %h want %h", obs, e); end
    checks++;
    if ({id_valid, alu_op, imm_ext, dest_reg, reg_write} !== {1'b1, 3'd3, 32'hcccc0000, 5'd17, 1'b1}) begin
      errors++; $display("FAIL lui_fields got v%0d op%0d imm %h dst %0d rw%0d want v1 op3 imm cccc0000 dst 17 rw1",
                         id_valid, alu_op, imm_ext, dest_reg, reg_write);
    end
  endtask

  task automatic test_beq();
    @(negedge clk);
    drive(32'h1254fffe, 32'h14, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL beq got %h want %h", obs, e); end
    checks++;
    if ({pc_src, br_target} !== {2'd1, 32'h0000000c}) begin
      errors++; $display("FAIL beq_fields got pc_src %0d br %h want 1 0000000c", pc_src, br_target);
    end
  endtask

  task automatic test_jal();
    @(negedge clk);
    drive(32'h0c000010, 32'h20, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL jal got %h want %h", obs, e); end
    checks++;
    if ({pc_src, j_target, dest_reg, link_data} !== {2'd2, 32'h40, 5'd31, 32'h20}) begin
      errors++; $display("FAIL jal_fields got pc_src %0d j %h dst %0d link %h want 2 40 31 20",
                         pc_src, j_target, dest_reg, link_data);
    end
  endtask

  task automatic test_mix();
    logic [31:0] tbl [10];
    logic        vld [10];
    tbl[0] = ADDU;                                       vld[0] = 1;
    tbl[1] = {6'h00, 5'd20, 5'd17, 5'd4, 5'd0, 6'h23};   vld[1] = 1;
    tbl[2] = {6'h00, 5'd17, 5'd0, 5'd0, 5'd0, 6'h08};    vld[2] = 1;
    tbl[3] = 32'h0;                                      vld[3] = 1;
    tbl[4] = {6'h0d, 5'd1, 5'd2, 16'h8001};              vld[4] = 1;
    tbl[5] = LW;                                         vld[5] = 1;
    tbl[6] = {6'h2b, 5'd5, 5'd20, 16'h0010};             vld[6] = 1;
    tbl[7] = {6'h02, 26'h3ffffff};                       vld[7] = 1;
    tbl[8] = ADDU;                                       vld[8] = 0;
    tbl[9] = {6'h04, 5'd1, 5'd1, 16'h7fff};              vld[9] = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(tbl[k], 32'hf0000000 + 32'(k * 4), vld[k], 0, 0, 0, 5'd0, 32'h0);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mix[%0d] got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    drive(ADDU, 32'h200, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sf_load got %h want %h", obs, e); end
    @(negedge clk);
    drive(LW, 32'h204, 1, 1, 1, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sf_flush got %h want %h", obs, e); end
    checks++;
    if ({id_valid, reg_write, mem_read, mem_write, pc_src, alu_op} !== 9'h0) begin
      errors++; $display("FAIL sf_flush_ctl got %b want 0", {id_valid, reg_write, mem_read, mem_write, pc_src, alu_op});
    end
    @(negedge clk);
    drive(LW, 32'h208, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL sf_lw got %h want %h", obs, e); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(32'h0c000010, 32'h300 + 32'(k), 1, 1, 0, 0, 5'd0, 32'h0);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sf_stall[%0d] got %h want %h", k, obs, e); end
      checks++;
      if ({id_valid, mem_read, reg_write, alu_src, dest_reg, pc_src} !== {4'b1111, 5'd6, 2'd0}) begin
        errors++; $display("FAIL sf_stall_lw[%0d] got v%0d mr%0d rw%0d as%0d dst%0d pcs%0d want 1 1 1 1 6 0",
                           k, id_valid, mem_read, reg_write, alu_src, dest_reg, pc_src);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    @(negedge clk);
    drive(ADDU, 32'h400, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL byp_load got %h want %h", obs, e); end
    @(negedge clk);
`ifdef ID_WB_BYPASS_EN
    want = 32'hdeadbeef;
`else
    want = m_regs[17];
`endif
    drive(32'h0, 32'h0, 0, 1, 0, 1, 5'd17, 32'hdeadbeef);
    #1; checks++;
    if (rs_data !== want) begin errors++; $display("FAIL byp_same_cycle got %h want %h", rs_data, want); end
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL byp_next got %h want %h", obs, e); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive(32'h3c11cccc, 32'h500, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL zr_load got %h want %h", obs, e); end
    @(negedge clk);
    drive(32'h0, 32'h0, 0, 1, 0, 1, 5'd0, 32'hffffffff);
    #1; checks++;
    if (rs_data !== 32'h0) begin errors++; $display("FAIL zr_same_cycle got %h want 0", rs_data); end
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL zr_next got %h want %h", obs, e); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    drive(32'hfc000000, 32'h600, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ill_slot got %h want %h", obs, e); end
    checks++;
    if ({id_valid, reg_write, illegal} !== 3'b100) begin
      errors++; $display("FAIL ill_slot_fields got %b want 100", {id_valid, reg_write, illegal});
    end
    @(negedge clk);
    drive(ADDU, 32'h604, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL ill_set got %h want %h", obs, e); end
    checks++;
    if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", illegal); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(LW, 32'h608, k[0], 0, (k == 1), 0, 5'd0, 32'h0);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ill_hold[%0d] got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_reset_override();
    @(negedge clk);
    stall = 1; flush = 1; if_valid = 1; instr_in = LW; pc_plus4_in = 32'h700;
    #2 rst = 0;
    model_reset();
    #1;
    e = exp_of(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rso_immediate got %h want %h", obs, e); end
    @(posedge clk); #1; checks++;
    if (obs !== e) begin errors++; $display("FAIL rso_held got %h want %h", obs, e); end
    @(negedge clk);
    rst = 1;
    drive(32'h0c000010, 32'h20, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rso_first_load got %h want %h", obs, e); end
    @(negedge clk);
    drive(ADDU, 32'h24, 1, 0, 0, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rso_regs_cleared got %h want %h", obs, e); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_regfile();
    test_lui();
    test_beq();
    test_jal();
    test_mix();
    test_stall_flush();
    test_bypass();
    test_zero_reg();
    test_illegal();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 instr_in  in  32  fetched instruction from the fetch unit.
REQ-005 pc_plus4_in  in  32  address of fetched instruction + 4.
REQ-006 if_valid  in  1  instr_in/pc_plus4_in are meaningful this cycle.
REQ-007 stall  in  1  hold the IF/ID register contents.
REQ-008 flush  in  1  squash the IF/ID register contents.
REQ-009 wb_we, wb_addr, wb_data  in  1/5/32  register-file write port.
REQ-010 id_valid  out  1  the decode slot holds a live instruction.
REQ-011 rs_data, rt_data  out  32/32  register-file reads of instr[25:21], instr[20:16].
REQ-012 imm_ext  out  32  extended immediate per REQ-020.
REQ-013 pc_src  out  2  0 sequential, 1 beq, 2 j/jal, 3 jr.
REQ-014 br_target, j_target  out  32/32  branch and jump destinations.
REQ-015 reg_write, mem_read, mem_write, alu_src  out  1 each  datapath controls.
REQ-016 alu_op  out  3  0 add, 1 sub, 2 or, 3 lui-pass; dest_reg out 5; link_data out 32; illegal out 1.

Function
REQ-017 IF/ID register SHALL load instr_in, pc_plus4_in, if_valid on each rising edge when flush=0 and stall=0.
REQ-018 flush=1 SHALL clear id_valid and instruction register to 0 on the next edge; flush SHALL take priority over simultaneous stall.
REQ-019 stall=1, flush=0 SHALL hold the IF/ID register and id_valid unchanged.
REQ-020 imm_ext: ori zero-extended; lui {imm,16'h0}; all others sign-extended.
REQ-021 br_target SHALL equal pc_plus4 + (sign-extended imm << 2), modulo 2^32.
REQ-022 j_target SHALL equal {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-023 Decoded set: addu, subu, jr, sll-zero nop (opcode 0); ori, lui, lw, sw, beq, j, jal.
REQ-024 dest_reg: rd for R-type, rt for ori/lui/lw, 31 for jal; link_data = pc_plus4 for jal, else 0.
REQ-025 pc_src SHALL be 1 for beq regardless of operand equality; branch resolution is downstream.
REQ-026 id_valid=0 SHALL force reg_write, mem_read, mem_write, pc_src, alu_op, illegal-pulse to 0.
REQ-027 Undecoded opcode/funct with id_valid=1 SHALL set sticky illegal on next edge and be treated as nop.
REQ-028 Register file: 32x32; write on rising edge when wb_we=1 and wb_addr!=0; register 0 always reads 0.
REQ-029 Reads SHALL be combinational from the registered instruction fields.

Reset
REQ-030 rst=0 SHALL immediately clear id_valid, instruction and pc_plus4 registers, illegal, and all 32 registers.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both; first edge after release loads normally.

Configuration
REQ-032 Macro ID_WB_BYPASS_EN defined: a read whose address equals wb_addr (nonzero) with wb_we=1 SHALL return wb_data in the same cycle.
REQ-033 Macro ID_WB_BYPASS_EN undefined: such a read SHALL return the pre-write value; new value visible from the next cycle.

Verification
REQ-034 Reset, then instr_in=32'h3c11cccc, if_valid=1, one edge -> id_valid=1, alu_op=3, imm_ext=32'hcccc0000, dest_reg=17, reg_write=1.
REQ-035 beq 32'h1254fffe with pc_plus4_in=32'h14 -> pc_src=1, br_target=32'h0000000c.
REQ-036 jal 32'h0c000010, pc_plus4_in=32'h20 -> pc_src=2, j_target=32'h40, dest_reg=31, link_data=32'h20.
REQ-037 stall=1 and flush=1 same edge -> id_valid=0, all controls 0; stall alone 3 cycles -> outputs unchanged.
REQ-038 wb_we=1, wb_addr=0, wb_data=32'hffffffff -> rs_data=0 for rs=0; wb_addr=17 while decoding rs=17 -> wb_data same cycle only with ID_WB_BYPASS_EN.
REQ-039 opcode 6'h3f with id_valid=1 -> illegal=1 next edge, held until rst=0; reg_write=0.
